lsu: RTL and testbench

//   Load-store unit in the MEM stage. Producer of the load data and load-valid that the write-back stage selects when wb_sel=01.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_if.sv | 55 +++++
 rtl/lsu_align.sv | 49 ++++
 rtl/lsu.sv | 126 ++++++++++++
 tb/tb_lsu.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and defaults for the MEM-stage load-store unit.
package lsu_pkg;

  localparam int LSU_ADDR_W      = 32;
  localparam int LSU_DATA_W      = 32;
  localparam int LSU_TIMEOUT_CYC = 64;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } lsu_state_e;

  typedef struct packed {
    logic                  we;
    mem_size_e             size;
    logic                  uns;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] wdata;
  } lsu_req_t;

  // The reserved encoding 2'b11 behaves exactly like a word access.
  function automatic mem_size_e decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return MEM_B;
      2'b01:   return MEM_H;
      default: return MEM_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline-side request/result bundle and memory-side valid/ready bus bundle of the LSU.
interface lsu_req_if
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
);
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              stall;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              misaligned;
  logic              bus_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  stall, ld_valid, ld_data, misaligned, bus_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output stall, ld_valid, ld_data, misaligned, bus_err
  );
endinterface

interface lsu_bus_if
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
);
  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [3:0]        bus_wstrb;
  logic              bus_rsp_valid;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_req_ready, bus_rsp_valid, bus_rdata
  );

  modport slave (
    input  bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_req_ready, bus_rsp_valid, bus_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: alignment check, store strobe/data replication, load extract+extend.
module lsu_align
  import lsu_pkg::*;
(
  input  mem_size_e   req_size_i,
  input  logic [1:0]  req_addr_i,
  input  logic [31:0] req_data_i,
  output logic        misaligned_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  input  mem_size_e   ld_size_i,
  input  logic [1:0]  ld_addr_i,
  input  logic        ld_uns_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);
  logic [31:0] shifted;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    misaligned_o = 1'b0;
    wstrb_o      = 4'b1111;
    wdata_o      = req_data_i;
    case (req_size_i)
      MEM_B: begin
        wstrb_o = 4'b0001 << req_addr_i;
        wdata_o = {4{req_data_i[7:0]}};
      end
      MEM_H: begin
        misaligned_o = req_addr_i[0];
        wstrb_o      = 4'b0011 << {req_addr_i[1], 1'b0};
        wdata_o      = {2{req_data_i[15:0]}};
      end
      default: misaligned_o = |req_addr_i;
    endcase
  end

  assign shifted = rdata_i >> {ld_addr_i, 3'b000};

  always_comb begin
    ld_data_o = rdata_i;
    case (ld_size_i)
      MEM_B:   ld_data_o = {{24{~ld_uns_i & shifted[7]}}, shifted[7:0]};
      MEM_H:   ld_data_o = {{16{~ld_uns_i & shifted[15]}}, shifted[15:0]};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// MEM-stage load-store unit: one outstanding valid/ready bus transaction at a time,
// stalling the pipeline until the response (or a timeout) completes it.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = LSU_ADDR_W,
  parameter int DATA_W      = LSU_DATA_W,
  parameter int TIMEOUT_CYC = LSU_TIMEOUT_CYC
) (
  input logic       clk,
  input logic       rst,
  lsu_req_if.slave  req,
  lsu_bus_if.master bus
);
  localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e        state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic              err_q, err_d;

  mem_size_e         in_size;
  logic              in_mis;
  logic [3:0]        in_wstrb;
  logic [DATA_W-1:0] in_wdata;
  logic [DATA_W-1:0] ld_ext;
  logic              timeout_hit;

  assign in_size = decode_size(req.req_size);

  lsu_align u_align (
    .req_size_i   (in_size),
    .req_addr_i   (req.req_addr[1:0]),
    .req_data_i   (req.req_wdata),
    .misaligned_o (in_mis),
    .wstrb_o      (in_wstrb),
    .wdata_o      (in_wdata),
    .ld_size_i    (req_q.size),
    .ld_addr_i    (req_q.addr[1:0]),
    .ld_uns_i     (req_q.uns),
    .rdata_i      (bus.bus_rdata),
    .ld_data_o    (ld_ext)
  );

  // A response arriving on the last counted cycle still wins over the timeout.
  assign timeout_hit = (state_q == RESP) && !bus.bus_rsp_valid && (cnt_q == CNT_LAST);

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req.req_valid && !in_mis) state_d = REQ;
      REQ:     if (bus.bus_req_ready) state_d = RESP;
      RESP:    if (bus.bus_rsp_valid || (cnt_q == CNT_LAST)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req.stall         = 1'b0;
    req.misaligned    = 1'b0;
    req.ld_valid      = 1'b0;
    bus.bus_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req.stall      = req.req_valid && !in_mis;
        req.misaligned = req.req_valid && in_mis;
      end
      REQ: begin
        req.stall         = 1'b1;
        bus.bus_req_valid = 1'b1;
      end
      RESP:    req.stall    = 1'b1;
      DONE:    req.ld_valid = !req_q.we && !err_q;
      default: ;
    endcase
  end

  always_comb begin
    req_d     = req_q;
    wstrb_d   = wstrb_q;
    ld_data_d = ld_data_q;
    cnt_d     = (state_q == RESP) ? cnt_q + CNT_W'(1) : '0;
    err_d     = timeout_hit;
    if ((state_q == IDLE) && req.req_valid && !in_mis) begin
      req_d = '{we: req.req_we, size: in_size, uns: req.req_unsigned,
                addr: req.req_addr, wdata: in_wdata};
      wstrb_d = req.req_we ? in_wstrb : 4'b0000;
    end
    if ((state_q == RESP) && bus.bus_rsp_valid) ld_data_d = ld_ext;
    else if (timeout_hit)                       ld_data_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= '0;
      wstrb_q   <= '0;
      cnt_q     <= '0;
      ld_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      req_q     <= req_d;
      wstrb_q   <= wstrb_d;
      cnt_q     <= cnt_d;
      ld_data_q <= ld_data_d;
      err_q     <= err_d;
    end
  end

  assign req.ld_data   = ld_data_q;
  assign req.bus_err   = err_q;
  assign bus.bus_we    = req_q.we;
  assign bus.bus_addr  = {req_q.addr[ADDR_W-1:2], 2'b00};
  assign bus.bus_wdata = req_q.wdata;
  assign bus.bus_wstrb = wstrb_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized loads/stores against a behavioural model.
module tb_lsu;
  import lsu_pkg::LSU_TIMEOUT_CYC;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  lsu_req_if rq ();
  lsu_bus_if bs ();

  lsu dut (
    .clk (clk),
    .rst (rst),
    .req (rq),
    .bus (bs)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: byte offsets and widths expressed as plain arithmetic.
  function automatic bit exp_mis(input logic [1:0] size, input logic [31:0] addr);
    int off = int'(addr % 4);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return (off % 2) != 0;
      default: return off != 0;
    endcase
  endfunction

  function automatic logic [3:0] exp_strb(input logic we, input logic [1:0] size,
                                          input logic [31:0] addr);
    int off = int'(addr % 4);
    if (!we) return 4'b0000;
    case (size)
      2'd0:    return 4'(1 << off);
      2'd1:    return 4'(3 << off);
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd0:    return {24'b0, d[7:0]} * 32'h0101_0101;
      2'd1:    return {16'b0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] w = rdata >> (8 * (addr % 4));
    logic [31:0] r;
    case (size)
      2'd0: begin
        r = {24'b0, w[7:0]};
        if (!uns && r >= 32'd128) r = r - 32'd256;
      end
      2'd1: begin
        r = {16'b0, w[15:0]};
        if (!uns && r >= 32'd32768) r = r - 32'd65536;
      end
      default: r = rdata;
    endcase
    return r;
  endfunction

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
    rq.req_valid    = 1'b1;
    rq.req_we       = we;
    rq.req_size     = size;
    rq.req_unsigned = uns;
    rq.req_addr     = addr;
    rq.req_wdata    = wd;
  endtask

  // One complete transaction from IDLE back to IDLE; rsp_dly >= TIMEOUT means no response.
  task automatic run_txn(input string name, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdata, input int rdy_dly, input int rsp_dly);
    bit          mis  = exp_mis(size, addr);
    bit          tmo  = rsp_dly >= LSU_TIMEOUT_CYC;
    int          last = tmo ? LSU_TIMEOUT_CYC - 1 : rsp_dly;
    logic [3:0]  strb = exp_strb(we, size, addr);
    logic [31:0] aexp = addr - (addr % 4);

    drive_req(we, size, uns, addr, wd);
    bs.bus_req_ready = 1'b0;
    bs.bus_rsp_valid = 1'b0;
    @(negedge clk);
    check_bit({name, " accept stall"}, rq.stall, !mis);
    check_bit({name, " accept misaligned"}, rq.misaligned, mis);
    check_bit({name, " accept bus_req_valid"}, bs.bus_req_valid, 1'b0);
    next_cycle();

    if (mis) begin
      rq.req_valid = 1'b0;
      @(negedge clk);
      check_bit({name, " after-mis stall"}, rq.stall, 1'b0);
      check_bit({name, " after-mis bus_req_valid"}, bs.bus_req_valid, 1'b0);
      check_bit({name, " after-mis pulse"}, rq.misaligned, 1'b0);
      next_cycle();
      return;
    end

    for (int k = 0; k <= rdy_dly; k++) begin
      bs.bus_req_ready = (k == rdy_dly);
      bs.bus_rsp_valid = (k < rdy_dly) && ($urandom_range(0, 1) == 1);
      bs.bus_rdata     = $urandom;
      @(negedge clk);
      check_bit({name, " req bus_req_valid"}, bs.bus_req_valid, 1'b1);
      check_bit({name, " req stall"}, rq.stall, 1'b1);
      check_bit({name, " req bus_we"}, bs.bus_we, we);
      check_word({name, " req bus_addr"}, bs.bus_addr, aexp);
      check_word({name, " req bus_wstrb"}, {28'b0, bs.bus_wstrb}, {28'b0, strb});
      if (we) check_word({name, " req bus_wdata"}, bs.bus_wdata, exp_wdata(size, wd));
      next_cycle();
    end
    bs.bus_req_ready = 1'b0;

    for (int k = 0; k <= last; k++) begin
      bs.bus_rsp_valid = !tmo && (k == rsp_dly);
      bs.bus_rdata     = bs.bus_rsp_valid ? rdata : $urandom;
      @(negedge clk);
      check_bit({name, " resp stall"}, rq.stall, 1'b1);
      check_bit({name, " resp bus_req_valid"}, bs.bus_req_valid, 1'b0);
      check_bit({name, " resp ld_valid"}, rq.ld_valid, 1'b0);
      next_cycle();
    end

    // DONE: pipeline released; a new request or stray response here must be ignored.
    bs.bus_rsp_valid = ($urandom_range(0, 1) == 1);
    bs.bus_rdata     = $urandom;
    drive_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, $urandom, $urandom);
    rq.req_valid = ($urandom_range(0, 1) == 1);
    @(negedge clk);
    check_bit({name, " done stall"}, rq.stall, 1'b0);
    check_bit({name, " done ld_valid"}, rq.ld_valid, !we && !tmo);
    check_bit({name, " done bus_err"}, rq.bus_err, tmo);
    check_bit({name, " done misaligned"}, rq.misaligned, 1'b0);
    if (tmo)      check_word({name, " done ld_data"}, rq.ld_data, 32'h0);
    else if (!we) check_word({name, " done ld_data"}, rq.ld_data, exp_load(size, uns, addr, rdata));
    next_cycle();

    rq.req_valid     = 1'b0;
    bs.bus_rsp_valid = 1'b0;
    @(negedge clk);
    check_bit({name, " idle ld_valid"}, rq.ld_valid, 1'b0);
    check_bit({name, " idle bus_err"}, rq.bus_err, 1'b0);
    check_bit({name, " idle stall"}, rq.stall, 1'b0);
    check_bit({name, " idle bus_req_valid"}, bs.bus_req_valid, 1'b0);
    next_cycle();
  endtask

  initial begin
    rst              = 1'b1;
    rq.req_valid     = 1'b0;
    rq.req_we        = 1'b0;
    rq.req_size      = 2'b00;
    rq.req_unsigned  = 1'b0;
    rq.req_addr      = '0;
    rq.req_wdata     = '0;
    bs.bus_req_ready = 1'b0;
    bs.bus_rsp_valid = 1'b0;
    bs.bus_rdata     = '0;

    next_cycle();
    @(negedge clk);
    check_bit("reset stall", rq.stall, 1'b0);
    check_bit("reset ld_valid", rq.ld_valid, 1'b0);
    check_bit("reset misaligned", rq.misaligned, 1'b0);
    check_bit("reset bus_err", rq.bus_err, 1'b0);
    check_bit("reset bus_req_valid", bs.bus_req_valid, 1'b0);
    check_bit("reset bus_we", bs.bus_we, 1'b0);
    check_word("reset ld_data", rq.ld_data, 32'h0);
    check_word("reset bus_addr", bs.bus_addr, 32'h0);
    check_word("reset bus_wdata", bs.bus_wdata, 32'h0);
    check_word("reset bus_wstrb", {28'b0, bs.bus_wstrb}, 32'h0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    run_txn("lb",  1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF_1234, 0, 0);
    run_txn("lhu", 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h8001_5555, 0, 0);
    run_txn("lw",  1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0);
    run_txn("sb",  1'b1, 2'd0, 1'b0, 32'h101, 32'hAB, 32'h0, 0, 0);
    run_txn("sh",  1'b1, 2'd1, 1'b0, 32'h102, 32'h1234, 32'h0, 0, 0);
    run_txn("lw-mis", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h0, 0, 0);
    run_txn("sw-slow", 1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFE_F00D, 32'h0, 5, 0);
    run_txn("lw-timeout", 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'h1234_5678, 0, LSU_TIMEOUT_CYC);

    // Reset while waiting for a response, then a stray late response.
    drive_req(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
    @(negedge clk);
    next_cycle();
    bs.bus_req_ready = 1'b1;
    @(negedge clk);
    next_cycle();
    bs.bus_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_bit("rst-resp stall before edge", rq.stall, 1'b1);
    next_cycle();
    rst = 1'b0;
    rq.req_valid = 1'b0;
    @(negedge clk);
    check_bit("rst-resp stall", rq.stall, 1'b0);
    check_bit("rst-resp bus_req_valid", bs.bus_req_valid, 1'b0);
    check_word("rst-resp bus_addr", bs.bus_addr, 32'h0);
    next_cycle();
    bs.bus_rsp_valid = 1'b1;
    bs.bus_rdata     = 32'h5A5A_5A5A;
    @(negedge clk);
    check_bit("late rsp ld_valid", rq.ld_valid, 1'b0);
    check_bit("late rsp stall", rq.stall, 1'b0);
    next_cycle();
    bs.bus_rsp_valid = 1'b0;
    @(negedge clk);
    check_bit("late rsp ld_valid next", rq.ld_valid, 1'b0);
    check_word("late rsp ld_data", rq.ld_data, 32'h0);
    next_cycle();
    run_txn("lw-after-rst", 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0BAD_F00D, 0, 1);

    for (int i = 0; i < 40; i++) begin
      run_txn("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 32'h1000 | 32'($urandom_range(0, 255)),
              $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 5));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
